// File: rtl/muldiv_if.sv
// Datapath-to-multiply/divide-unit bus: operation request plus the HI/LO result registers.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    // start is a single-cycle request that is only taken while busy is low;
    // op/a/b must be valid in that same cycle. Requests seen while busy is high
    // are dropped, never queued. done pulses for exactly one cycle, together
    // with the first cycle in which hi/lo hold the new result.
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit, one bit per cycle, with architectural HI/LO.
// Define MULDIV_EARLY_TERM_EN to let MULTU finish once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    muldiv_if.slave    bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    // MULTU: mcand_sh is the multiplicand shifted left each cycle, mplier the
    // multiplier shifted right. DIVU: mcand_sh[WIDTH-1:0] is the divisor and
    // mplier holds the dividend bits being shifted out / quotient bits shifted in.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               last_iter;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand_sh : '0);
        shifted  = {rem, mplier[WIDTH-1]};
        ge       = shifted >= {1'b0, mcand_sh[WIDTH-1:0]};
        // A restoring step never leaves a remainder >= divisor, so WIDTH bits suffice.
        rem_next = ge ? (shifted[WIDTH-1:0] - mcand_sh[WIDTH-1:0]) : shifted[WIDTH-1:0];
        quo_next = {mplier[WIDTH-2:0], ge};
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!op_r && (mplier[WIDTH-1:1] == '0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r     <= bus.op;
                        cnt      <= '0;
                        acc      <= '0;
                        rem      <= '0;
                        mcand_sh <= {{WIDTH{1'b0}}, (bus.op ? bus.b : bus.a)};
                        mplier   <= bus.op ? bus.a : bus.b;
                        busy_r   <= 1'b1;
                        if (bus.op && (bus.b == '0)) begin
                            hi_r   <= bus.a;
                            lo_r   <= '1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
`ifdef MULDIV_EARLY_TERM_EN
                        else if (!bus.op && (bus.b == '0)) begin
                            hi_r   <= '0;
                            lo_r   <= '0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
`endif
                        else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_r) begin
                        rem    <= rem_next;
                        mplier <= quo_next;
                    end else begin
                        acc      <= acc_next;
                        mcand_sh <= mcand_sh << 1;
                        mplier   <= mplier >> 1;
                    end
                    if (last_iter) begin
                        if (op_r) begin
                            hi_r <= rem_next;
                            lo_r <= quo_next;
                        end else begin
                            hi_r <= acc_next[2*WIDTH-1:WIDTH];
                            lo_r <= acc_next[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign state_dbg = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, busy/done shape, HI/LO results and stability, reset abort.
// Latency expectations follow MULDIV_EARLY_TERM_EN when the bench is built with it.
module tb_muldiv_unit;
    localparam int W = 32;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         test_cnt;
    int         fail_cnt;
    logic [2*W-1:0] exp_q[$];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one op in cycle 0, then watches cycles 1.. until the unit is idle again.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_done_cyc);
        logic [W-1:0]   prev_hi;
        logic [W-1:0]   prev_lo;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        int done_cyc;
        int done_cnt;
        int busy_cnt;
        int stale_err;
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        res = '0;
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        stale_err = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    res = {bus.hi, bus.lo};
                end
            end else if (bus.busy && ((bus.hi !== prev_hi) || (bus.lo !== prev_lo))) begin
                stale_err++;
            end
            if (!bus.busy) break;
        end
        exp = exp_q.pop_front();
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done_cyc));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " hilo_stable"}, 64'(stale_err), 64'd0);
        check({tag, " result"}, res, exp);
    endtask

`ifndef MULDIV_EARLY_TERM_EN
    task automatic busy_reset_test();
        int done_cnt;
        // Ignored starts in RUN (cycle 5) and DONE (cycle 33).
        exp_q.push_back({32'd0, 32'd42});
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(posedge clk); #1;
            bus.start = (cyc == 5) || (cyc == 33);
            if (bus.start) begin
                bus.op = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
            end
            if (cyc == 33) begin
                check("ign done_c33", 64'(bus.done), 64'd1);
                check("ign result", {bus.hi, bus.lo}, exp_q.pop_front());
            end
            if (cyc == 35) check("ign idle_c35", 64'(bus.busy), 64'd0);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (cyc == 10) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst busy_c11", 64'(bus.busy), 64'd0);
        check("rst done_c11", 64'(bus.done), 64'd0);
        check("rst hilo_c11", {bus.hi, bus.lo}, 64'd0);
        check("rst state_c11", 64'(state_dbg), 64'd0);
        done_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("rst no_trace", 64'(done_cnt), 64'd0);
    endtask
`endif

    initial begin
        int lat_3x5;
        int lat_by1;
        int lat_by0;
        test_cnt = 0;
        fail_cnt = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef MULDIV_EARLY_TERM_EN
        lat_3x5 = 4;
        lat_by1 = 2;
        lat_by0 = 1;
`else
        lat_3x5 = 33;
        lat_by1 = 33;
        lat_by0 = 33;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset state", 64'(state_dbg), 64'd0);

        exp_q.push_back({32'h0000_0000, 32'h0000_000F});
        run_op("mul 3x5", 1'b0, 32'd3, 32'd5, lat_3x5);
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        run_op("mul max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        exp_q.push_back({32'd2, 32'd14});
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 33);
        exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
        run_op("div by0", 1'b1, 32'h0000_1234, 32'd0, 1);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        run_op("mul x1", 1'b0, 32'hDEAD_BEEF, 32'd1, lat_by1);
        exp_q.push_back({32'd0, 32'd0});
        run_op("mul x0", 1'b0, 32'h1234_5678, 32'd0, lat_by0);
        exp_q.push_back({32'h0000_0000, 32'h0000_0005});
        run_op("div 0xFF/0x33", 1'b1, 32'hFF, 32'h33, 33);
        exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        run_op("div max/1", 1'b1, 32'hFFFF_FFFF, 32'd1, 33);
`ifndef MULDIV_EARLY_TERM_EN
        busy_reset_test();
`endif
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
